// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences byte/half/word LSU requests onto a 16-bit byte-laned SRAM.
// Optional macro SRAM_CTRL_MISALIGN_ERR_EN rejects misaligned and size-11 requests.
module sram_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done, idle;

    logic              we_q, sext_q, byte_q, word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       lo_q, lo_d;

    logic              in_byte, in_word, bad;
    logic [ADDR_W-1:0] in_addr;
    logic              cur_we, cur_byte, cur_word;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;

    logic [ADDR_W-1:0] addr_d;
    logic [15:0]       dq_o_d;
    logic              dq_oe_d, we_n_d, ce_n_d, oe_n_d, lb_n_d, ub_n_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [31:0]       rdata_d;
    logic [7:0]        rd_byte;
    logic              unused_hi;

    assign unused_hi = ^req_addr[31:ADDR_W];
    assign idle      = (state_q == IDLE);
    assign req_ready = idle;
    assign done      = (cnt_q == LAST);
    assign in_byte   = (req_size == 2'b00);
    assign in_word   = req_size[1];

    always_comb begin
        in_addr = req_addr[ADDR_W-1:0];
        if (!in_byte) in_addr[0] = 1'b0;
        if (in_word)  in_addr[1] = 1'b0;
    end

`ifdef SRAM_CTRL_MISALIGN_ERR_EN
    assign bad = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | (in_word & (|req_addr[1:0]));
`else
    assign bad = 1'b0;
`endif

    // The accepting cycle already programs ACC0, so look at the live request.
    assign cur_we    = idle ? req_we    : we_q;
    assign cur_byte  = idle ? in_byte   : byte_q;
    assign cur_word  = idle ? in_word   : word_q;
    assign cur_addr  = idle ? in_addr   : addr_q;
    assign cur_wdata = idle ? req_wdata : wdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = bad ? RESP : ACC0;
            ACC0:    if (done) state_d = cur_word ? ACC1 : RESP;
            ACC1:    if (done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_comb begin
        addr_d  = sram_addr;
        dq_o_d  = sram_dq_o;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        if (state_d == ACC0 || state_d == ACC1) begin
            ce_n_d  = 1'b0;
            we_n_d  = ~cur_we;
            oe_n_d  = cur_we;
            dq_oe_d = cur_we;
            lb_n_d  = cur_byte & cur_addr[0];
            ub_n_d  = cur_byte & ~cur_addr[0];
            addr_d  = {cur_addr[ADDR_W-1:1], 1'b0};
            if (state_d == ACC1) addr_d = addr_d + ADDR_W'(2);
            if (cur_byte)
                dq_o_d = {2{cur_wdata[7:0]}};
            else if (state_d == ACC1)
                dq_o_d = cur_wdata[31:16];
            else
                dq_o_d = cur_wdata[15:0];
        end
    end

    assign rd_byte = addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];

    always_comb begin
        lo_d        = lo_q;
        rdata_d     = rsp_rdata;
        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = idle & (state_d == RESP);
        if (state_q == ACC0 && done) lo_d = sram_dq_i;
        if (state_d == RESP && state_q != RESP) begin
            rdata_d = '0;
            if (!idle && !we_q) begin
                if (byte_q)
                    rdata_d = {{24{sext_q & rd_byte[7]}}, rd_byte};
                else if (!word_q)
                    rdata_d = {{16{sext_q & sram_dq_i[15]}}, sram_dq_i};
                else
                    rdata_d = {sram_dq_i, lo_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lo_q       <= '0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            byte_q     <= 1'b0;
            word_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            if (idle) begin
                we_q    <= req_we;
                sext_q  <= req_sext;
                byte_q  <= in_byte;
                word_q  <= in_word;
                addr_q  <= in_addr;
                wdata_q <= req_wdata;
            end
            rsp_valid  <= rsp_valid_d;
            rsp_err    <= rsp_err_d;
            rsp_rdata  <= rdata_d;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= dq_oe_d;
            sram_we_n  <= we_n_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_lb_n  <= lb_n_d;
            sram_ub_n  <= ub_n_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl against a byte-laned SRAM model.
// The model commits a write only once its WE pulse has lasted a full phase.
module tb_sram_ctrl;

    localparam int W  = 3;
    localparam int AW = 20;

`ifdef SRAM_CTRL_MISALIGN_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid, req_ready, req_we, req_sext;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n;
    logic          sram_lb_n, sram_ub_n;

    sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   ce_cnt  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!sram_ce_n) ce_cnt <= ce_cnt + 1;

    // SRAM model
    logic [15:0]   mem [2048];
    logic          pend = 1'b0;
    logic [AW-1:0] pa;
    logic [15:0]   pd;
    logic          plb, pub;
    int            plen;
    logic          bd_we = 1'b0;
    logic [10:0]   bd_idx;
    logic [15:0]   bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (pend && plen >= W && (sram_ce_n || sram_we_n || sram_addr != pa)) begin
            if (!plb) mem[pa[11:1]][7:0]  <= pd[7:0];
            if (!pub) mem[pa[11:1]][15:8] <= pd[15:8];
        end
        if (!sram_ce_n && !sram_we_n) begin
            if (pend && sram_addr == pa) begin
                plen <= plen + 1;
            end else begin
                pend <= 1'b1;
                pa   <= sram_addr;
                pd   <= sram_dq_o;
                plb  <= sram_lb_n;
                pub  <= sram_ub_n;
                plen <= 1;
            end
        end else begin
            pend <= 1'b0;
        end
    end

    always_comb begin
        sram_dq_i = 16'h0;
        if (!sram_ce_n && !sram_oe_n && !sram_dq_oe) begin
            if (!sram_lb_n) sram_dq_i[7:0]  = mem[sram_addr[11:1]][7:0];
            if (!sram_ub_n) sram_dq_i[15:8] = mem[sram_addr[11:1]][15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_pending", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_lat", 32'(cyc - e.cyc), 32'(e.lat));
            end
        end
    end

    task automatic bd_write(input logic [10:0] idx, input logic [15:0] d);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Called and returns at a negedge; hold keeps req_valid high afterwards.
    task automatic do_req(input logic we, input logic [1:0] size,
                          input logic sext, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] erd,
                          input logic eerr, input int elat, input bit hold,
                          output int waited);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        waited    = 0;
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = elat;
        e.cyc   = cyc;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_size  = 2'($urandom);
            req_sext  = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int wt;
        int base;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wt;
        int base;
        int n;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sext  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq", 32'({sram_dq_oe, sram_dq_o}), 32'd0);
        chk("rst_ctl", 32'({sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n}),
            32'h1f);

        bd_write(11'h100, 16'h5A5A);
        bd_write(11'h101, 16'h8001);

        do_req(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2*W+1, 0, wt);
        drain();
        chk("st_word_lo", 32'(mem[11'h080]), 32'hBEEF);
        chk("st_word_hi", 32'(mem[11'h081]), 32'hDEAD);
        do_req(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2*W+1, 0, wt);

        do_req(1, 2'b00, 0, 32'h201, 32'h11223380, 32'h0, 0, W+1, 0, wt);
        drain();
        chk("st_byte_ub", 32'(mem[11'h100]), 32'h805A);
        do_req(0, 2'b00, 1, 32'h201, 32'h0, 32'hFFFFFF80, 0, W+1, 0, wt);
        do_req(0, 2'b00, 0, 32'h201, 32'h0, 32'h00000080, 0, W+1, 0, wt);
        do_req(0, 2'b00, 1, 32'h200, 32'h0, 32'h0000005A, 0, W+1, 0, wt);

        do_req(0, 2'b01, 1, 32'h202, 32'h0, 32'hFFFF8001, 0, W+1, 0, wt);
        do_req(0, 2'b01, 0, 32'h202, 32'h0, 32'h00008001, 0, W+1, 0, wt);
        do_req(1, 2'b01, 0, 32'h204, 32'hFFFF1234, 32'h0, 0, W+1, 0, wt);
        drain();
        chk("st_half", 32'(mem[11'h102]), 32'h1234);

        base = ce_cnt;
        do_req(0, 2'b10, 0, 32'h102, 32'h0, ERR ? 32'h0 : 32'hDEADBEEF,
               ERR, ERR ? 1 : 2*W+1, 0, wt);
        drain();
        chk("misalign_ce", 32'(ce_cnt - base), ERR ? 32'd0 : 32'(2*W));
        do_req(0, 2'b11, 0, 32'h100, 32'h0, ERR ? 32'h0 : 32'hDEADBEEF,
               ERR, ERR ? 1 : 2*W+1, 0, wt);
        do_req(0, 2'b01, 0, 32'h203, 32'h0, ERR ? 32'h0 : 32'h00008001,
               ERR, ERR ? 1 : W+1, 0, wt);
        drain();

        do_req(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2*W+1, 1, wt);
        do_req(0, 2'b00, 0, 32'h201, 32'h0, 32'h00000080, 0, W+1, 0, wt);
        chk("b2b_wait", 32'(wt), 32'(2*W+1));
        drain();

        bd_write(11'h180, 16'h0000);
        bd_write(11'h181, 16'hAAAA);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h300;
        req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(sram_addr == 20'h302 && !sram_ce_n) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("acc1_reached", 32'(n < 50), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ctl", 32'({sram_we_n, sram_ce_n, sram_oe_n, sram_lb_n,
            sram_ub_n, sram_dq_oe}), 32'h3e);
        chk("rstmid_rsp", 32'(rsp_valid), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rstmid_lo", 32'(mem[11'h180]), 32'h5678);
        chk("rstmid_hi", 32'(mem[11'h181]), 32'hAAAA);
        do_req(0, 2'b10, 0, 32'h300, 32'h0, 32'hAAAA5678, 0, 2*W+1, 0, wt);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequencer between the CPU load/store unit and the 16-bit byte-laned asynchronous-style data SRAM (`dmem`-class part with active-low WE/CE/OE/LB/UB). It accepts one 32-bit byte/half/word request at a time over a valid/ready handshake. It splits word accesses into two 16-bit SRAM phases, drives byte-lane enables, and returns sign- or zero-extended read data on a one-cycle response strobe. All SRAM control outputs are registered; the top level builds the tri-state bus as `dq = sram_dq_oe ? sram_dq_o : 'z`.

## Interface
- `ADDR_W`, 20: SRAM byte-address width; request address bits above `ADDR_W-1` are ignored.
- `WAIT_CYCLES`, 1: cycles per SRAM access phase, minimum 1.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle, request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 store, 0 load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_sext` in 1: loads only; 1 sign-extend, 0 zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: load result, valid with `rsp_valid`; 0 for stores and errors.
- `rsp_err` out 1: request rejected, valid with `rsp_valid`.
- `sram_addr` out ADDR_W: byte address presented to SRAM (bit 0 always 0).
- `sram_dq_o` out 16: write data. `sram_dq_oe` out 1: drive bus. `sram_dq_i` in 16: read data.
- `sram_we_n`, `sram_ce_n`, `sram_oe_n`, `sram_lb_n`, `sram_ub_n` out 1 each: active-low controls.

## Operation
- States: IDLE, ACC0, ACC1, RESP. `req_ready` = 1 only in IDLE.
- IDLE + accept: latch request. Legal -> ACC0. Illegal (size 11, half with addr[0]=1, word with addr[1:0]≠0) -> RESP with err=1, no SRAM activity.
- ACC0: `sram_addr` = {addr[ADDR_W-1:1],0}, `ce_n`=0, lanes per below. Load: `oe_n`=0, `we_n`=1, `dq_oe`=0. Store: `we_n`=0, `oe_n`=1, `dq_oe`=1.
- ACC0 lasts WAIT_CYCLES cycles. Then the word size goes to ACC1; other sizes go to RESP.
- ACC1 (word only): `sram_addr` = ACC0 address + 2, both lanes, WAIT_CYCLES cycles, then -> RESP.
- Lanes (little-endian): byte addr[0]=0 -> `lb_n`=0, data on dq[7:0]; addr[0]=1 -> `ub_n`=0, data on dq[15:8]; half/word phases -> both lanes.
- Store data: byte replicated on both dq halves; half = wdata[15:0]; word ACC0 = wdata[15:0], ACC1 = wdata[31:16].
- Load capture: `sram_dq_i` sampled on the clock edge ending the last cycle of each phase. Byte selects the addressed lane. Word = {ACC1 data, ACC0 data`}. Extend per `req_sext`.
- RESP: `rsp_valid`=1 for exactly one cycle, all controls deasserted, -> IDLE. A new request is accepted earliest the cycle after RESP.
- Outside ACC0/ACC1: all `_n` outputs = 1, `dq_oe`=0, `sram_addr` holds last value.

## Timing
- Reset values: state IDLE, `req_ready`=1 after reset, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, all `_n`=1.
- Accept at edge T. ACC0 occupies cycles T+1..T+W (W=WAIT_CYCLES).
- Byte/half: `rsp_valid` at cycle T+W+1. Word: ACC1 at T+W+1..T+2W, `rsp_valid` at T+2W+1. Illegal: `rsp_valid` at T+1.
- Request fields are ignored while `req_ready`=0; latched copies are used throughout.
- `rst` asserted mid-access: at the next edge all controls return to reset values. The pending request is dropped and no response is issued. A partial word store leaves the low half written.

## Configuration
- `SRAM_CTRL_MISALIGN_ERR_EN` defined: misaligned or size-11 requests produce the error response described above.
- Undefined: `rsp_err` tied 0. Misaligned addresses are forced aligned (half clears addr[0], word clears addr[1:0]). Size 11 is treated as word.

## Test plan
- W=1, store word 0xDEADBEEF @0x100, then load word @0x100 -> SRAM[0x100]=0xBEEF, SRAM[0x102]=0xDEAD; load `rsp_rdata`=0xDEADBEEF, `rsp_valid` 3 cycles after accept.
- Store byte 0x80 @0x201 (ub_n=0 only); load byte @0x201 sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080; low byte @0x200 unchanged.
- Load half @0x202 with SRAM=0x8001, sext=1 -> 0xFFFF8001, latency W+1 with W=3 (4 cycles).
- Macro on: load word @0x102 -> `rsp_valid`=1, `rsp_err`=1, `rdata`=0 at T+1, `ce_n` never low. Macro off: same request accesses 0x100/0x102, `rsp_err`=0.
- Back-to-back `req_valid` held high: second request accepted only the cycle after the first `rsp_valid`; `req_ready`=0 throughout ACC0/ACC1/RESP.
- `rst` pulsed during ACC1 of a word store -> next cycle all `_n`=1, `dq_oe`=0, no `rsp_valid`; only the low half is written.
